// File: rtl/hpgp_itl_wr_ctrl.sv
// hpgp_itl_wr_ctrl
//
// Write/read sequencer in front of the HPGP turbo interleaver dual-port RAM.
// A PB payload arrives as a byte stream; each byte is split into four 2-bit
// pairs (LSB pair first) that are written to RAM addresses 0..N-1. Once the
// last pair has been written, addresses 0..N-1 are swept again with writes
// disabled so the RAM can emit natural-order and interleaved-order pairs to
// the constituent encoders.
//
// Ports
//   clk_i        single clock for all logic
//   n_rst_i      asynchronous, active-low reset
//   start_i      begin a PB (sampled only while idle)
//   pb_sel_i     PB size: 0=PB16 (64 pairs), 1=PB136 (544), 2=PB520 (2080),
//                3=reserved (raises err_o)
//   s_data_i     payload byte
//   s_vld_i      s_data_i valid
//   s_rdy_o      byte accepted when s_vld_i && s_rdy_o (combinational)
//   wdata_o      pair to RAM
//   waddr_o      RAM write/read address, 0..N-1
//   pb_offset_o  interleaver ROM offset for the selected PB size
//   wen_o        RAM write enable
//   din_vld_o    read-sweep valid to RAM
//   busy_o       high whenever a PB is in progress
//   done_o       one-cycle pulse at PB completion
//   err_o        one-cycle pulse on start with the reserved PB size
//
// All outputs except s_rdy_o are registered.

module hpgp_itl_wr_ctrl #(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic               start_i,
  input  logic [1:0]         pb_sel_i,
  input  logic [7:0]         s_data_i,
  input  logic               s_vld_i,
  output logic               s_rdy_o,
  output logic [D_WIDTH-1:0] wdata_o,
  output logic [A_WIDTH-1:0] waddr_o,
  output logic [A_WIDTH-1:0] pb_offset_o,
  output logic               wen_o,
  output logic               din_vld_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [A_WIDTH-1:0] ONE  = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] ZERO = '0;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] npairs_q, npairs_d;
  logic [A_WIDTH-1:0] nbytes_q, nbytes_d;
  logic [A_WIDTH-1:0] offset_q, offset_d;
  logic [A_WIDTH-1:0] acc_q, acc_d;
  logic [A_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]         byte_q, byte_d;
  logic [1:0]         k_q, k_d;
  logic               buf_full_q, buf_full_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic               din_vld_q, din_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [A_WIDTH-1:0] sel_pairs;
  logic [A_WIDTH-1:0] sel_offset;
  logic               sel_valid;
  logic               accept;

  // Pair k of a byte, LSB pair first.
  function automatic logic [1:0] pair_of(input logic [7:0] b, input logic [1:0] idx);
    logic [1:0] p;
    case (idx)
      2'd0:    p = b[1:0];
      2'd1:    p = b[3:2];
      2'd2:    p = b[5:4];
      default: p = b[7:6];
    endcase
    return p;
  endfunction

  // PB size decode: pair count and ROM table offset.
  always_comb begin
    sel_pairs  = ZERO;
    sel_offset = ZERO;
    sel_valid  = 1'b1;
    case (pb_sel_i)
      2'd0: begin
        sel_pairs  = A_WIDTH'(64);
        sel_offset = A_WIDTH'(0);
      end
      2'd1: begin
        sel_pairs  = A_WIDTH'(544);
        sel_offset = A_WIDTH'(64);
      end
      2'd2: begin
        sel_pairs  = A_WIDTH'(2080);
        sel_offset = A_WIDTH'(608);
      end
      default: sel_valid = 1'b0;
    endcase
  end

  // A new byte fits when the buffer is empty or is about to hand out its last
  // pair this cycle; reloading on the last pair keeps one write every cycle.
  assign s_rdy_o = (state_q == ST_WRITE) && (!buf_full_q || (k_q == 2'd3)) &&
                   (acc_q < nbytes_q);
  assign accept  = s_rdy_o && s_vld_i;

  // Next-state and registered-output logic. The buffer-full flag is the
  // write enable of the following cycle, so the pair selected here is what
  // the RAM sees next cycle.
  always_comb begin
    state_d    = state_q;
    npairs_d   = npairs_q;
    nbytes_d   = nbytes_q;
    offset_d   = offset_q;
    acc_d      = acc_q;
    wr_idx_d   = wr_idx_q;
    waddr_d    = waddr_q;
    byte_d     = byte_q;
    k_d        = k_q;
    buf_full_d = buf_full_q;
    wdata_d    = wdata_q;
    din_vld_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (sel_valid) begin
            state_d    = ST_WRITE;
            npairs_d   = sel_pairs;
            nbytes_d   = sel_pairs >> 2;
            offset_d   = sel_offset;
            acc_d      = ZERO;
            wr_idx_d   = ZERO;
            waddr_d    = ZERO;
            k_d        = 2'd0;
            buf_full_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        // wr_idx_q counts writes already presented, so reaching N means the
        // final write is on the RAM port this cycle and the sweep starts next.
        if (wr_idx_q == npairs_q) begin
          state_d    = ST_READ;
          buf_full_d = 1'b0;
          din_vld_d  = 1'b1;
          waddr_d    = ZERO;
        end else begin
          if (accept) begin
            byte_d     = s_data_i;
            k_d        = 2'd0;
            buf_full_d = 1'b1;
            acc_d      = acc_q + ONE;
          end else if (buf_full_q) begin
            if (k_q == 2'd3) begin
              buf_full_d = 1'b0;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
          if (buf_full_d) begin
            wdata_d  = D_WIDTH'(pair_of(byte_d, k_d));
            wr_idx_d = wr_idx_q + ONE;
          end
          // During a source stall the address parks on the next write slot.
          waddr_d = wr_idx_q;
        end
      end

      ST_READ: begin
        if (waddr_q == npairs_q - ONE) begin
          state_d = ST_DONE;
          waddr_d = ZERO;
          done_d  = 1'b1;
        end else begin
          din_vld_d = 1'b1;
          waddr_d   = waddr_q + ONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        offset_d = ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any partial byte and counts.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= ST_IDLE;
      npairs_q   <= '0;
      nbytes_q   <= '0;
      offset_q   <= '0;
      acc_q      <= '0;
      wr_idx_q   <= '0;
      waddr_q    <= '0;
      byte_q     <= '0;
      k_q        <= '0;
      buf_full_q <= 1'b0;
      wdata_q    <= '0;
      din_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      npairs_q   <= npairs_d;
      nbytes_q   <= nbytes_d;
      offset_q   <= offset_d;
      acc_q      <= acc_d;
      wr_idx_q   <= wr_idx_d;
      waddr_q    <= waddr_d;
      byte_q     <= byte_d;
      k_q        <= k_d;
      buf_full_q <= buf_full_d;
      wdata_q    <= wdata_d;
      din_vld_q  <= din_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wdata_o     = wdata_q;
  assign waddr_o     = waddr_q;
  assign pb_offset_o = offset_q;
  assign wen_o       = buf_full_q;
  assign din_vld_o   = din_vld_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hpgp_itl_wr_ctrl.sv
// tb_hpgp_itl_wr_ctrl
//
// Bench for hpgp_itl_wr_ctrl. A pair-queue model of the sequencer predicts
// every output each cycle; trackers record event cycles and counts that are
// then compared with hand-computed values for each scenario.

module tb_hpgp_itl_wr_ctrl;

  typedef enum {PH_IDLE, PH_WRITE, PH_READ, PH_DONE} phase_t;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  pbSel = 2'd0;
  logic [7:0]  sData = 8'd0;
  logic        sVld = 1'b0;
  logic        sRdy;
  logic [1:0]  wdata;
  logic [11:0] waddr;
  logic [11:0] pbOffset;
  logic        wen;
  logic        dinVld;
  logic        busy;
  logic        done;
  logic        err;

  hpgp_itl_wr_ctrl #(.D_WIDTH(2), .A_WIDTH(12)) dut (
    .clk_i(clk), .n_rst_i(nRst), .start_i(start), .pb_sel_i(pbSel),
    .s_data_i(sData), .s_vld_i(sVld), .s_rdy_o(sRdy), .wdata_o(wdata),
    .waddr_o(waddr), .pb_offset_o(pbOffset), .wen_o(wen), .din_vld_o(dinVld),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: wait bound expired, actual=timeout required=event", name);
  endtask

  // ---------------- behavioural model ----------------
  phase_t     mPhase = PH_IDLE;
  logic [1:0] pend[$];
  int         mPairs = 0, mBytes = 0, mOff = 0, mAcc = 0, mWcnt = 0;
  int         mWaddr = 0, mWdata = 0;
  bit         mWen = 0, mDin = 0, mDone = 0, mErr = 0, mBusy = 0;
  int         cycleCnt = 0;

  function automatic bit mRdy();
    return (mPhase == PH_WRITE) && (pend.size() == 0) && (mAcc < mBytes);
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mPhase = PH_IDLE;
      pend.delete();
      mPairs = 0; mBytes = 0; mOff = 0; mAcc = 0; mWcnt = 0;
      mWaddr = 0; mWdata = 0;
      mWen = 0; mDin = 0; mDone = 0; mErr = 0; mBusy = 0;
    end else begin
      bit rdy;
      rdy = mRdy();
      cycleCnt++;
      mDone = 0;
      mErr = 0;
      case (mPhase)
        PH_IDLE: begin
          if (start) begin
            if (pbSel == 2'd3) begin
              mErr = 1;
            end else begin
              mPairs = (pbSel == 2'd0) ? 64 : (pbSel == 2'd1) ? 544 : 2080;
              mOff   = (pbSel == 2'd0) ? 0 : (pbSel == 2'd1) ? 64 : 608;
              mBytes = mPairs / 4;
              mAcc = 0;
              mWcnt = 0;
              pend.delete();
              mPhase = PH_WRITE;
            end
          end
        end
        PH_WRITE: begin
          if (mWcnt == mPairs) begin
            mPhase = PH_READ;
            mWen = 0;
            mDin = 1;
            mWaddr = 0;
          end else begin
            if (rdy && sVld) begin
              for (int j = 0; j < 4; j++) pend.push_back(2'((sData >> (2 * j)) & 8'd3));
              mAcc++;
            end
            mWaddr = mWcnt;
            if (pend.size() > 0) begin
              mWdata = int'(pend.pop_front());
              mWen = 1;
              mWcnt++;
            end else begin
              mWen = 0;
            end
          end
        end
        PH_READ: begin
          if (mWaddr == mPairs - 1) begin
            mPhase = PH_DONE;
            mDin = 0;
            mWaddr = 0;
            mDone = 1;
          end else begin
            mWaddr++;
          end
        end
        default: begin
          mPhase = PH_IDLE;
          mOff = 0;
        end
      endcase
      mBusy = (mPhase != PH_IDLE);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (nRst) begin
      logic [63:0] actV, expV;
      actV = {28'd0, sRdy, wen, dinVld, busy, done, err, (wen ? wdata : 2'd0), waddr, pbOffset};
      expV = {28'd0, mRdy(), mWen, mDin, mBusy, mDone, mErr,
              (mWen ? 2'(mWdata) : 2'd0), 12'(mWaddr), 12'(mOff)};
      checkOutput($sformatf("outputs cycle %0d", cycleCnt), actV, expV);
    end
  end

  // ---------------- event trackers ----------------
  int startCycle = 0;
  int wrCount, rdCount, firstWr, lastWr, firstRd, lastRd, doneRel, busyFall;
  int hsCount, gapCount, gapFirstAddr, gapAddrChanges, offBad, e4Bad, firstWrAddr;
  int expOff;
  bit prevBusy = 0;

  always @(negedge clk) begin
    if (nRst) begin
      int rel;
      rel = cycleCnt - startCycle;
      if (wen) begin
        if (wrCount == 0) begin
          firstWr = rel;
          firstWrAddr = int'(waddr);
        end
        lastWr = rel;
        wrCount++;
        if (wdata != waddr[1:0]) e4Bad++;
      end else if (!dinVld && busy && wrCount > 0 && rdCount == 0) begin
        if (gapCount == 0) gapFirstAddr = int'(waddr);
        else if (int'(waddr) != gapFirstAddr) gapAddrChanges++;
        gapCount++;
      end
      if (dinVld) begin
        if (rdCount == 0) firstRd = rel;
        lastRd = rel;
        rdCount++;
      end
      if (done) doneRel = rel;
      if (prevBusy && !busy) busyFall = rel;
      prevBusy = busy;
      if (sVld && sRdy) hsCount++;
      if (busy && int'(pbOffset) != expOff) offBad++;
    end
  end

  task automatic clearTrackers(input int off);
    wrCount = 0; rdCount = 0; firstWr = -1; lastWr = -1; firstRd = -1; lastRd = -1;
    doneRel = -1; busyFall = -1; hsCount = 0; gapCount = 0; gapFirstAddr = -1;
    gapAddrChanges = 0; offBad = 0; e4Bad = 0; firstWrAddr = -1; expOff = off;
  endtask

  function automatic logic [7:0] byteOf(input int mode, input int i);
    return (mode == 0) ? 8'hE4 : 8'((i * 37 + 11) & 255);
  endfunction

  task automatic startPb(input logic [1:0] sel, input int off);
    clearTrackers(off);
    @(negedge clk);
    start = 1'b1;
    pbSel = sel;
    startCycle = cycleCnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit inject);
    int guard;
    sData = b;
    sVld = 1'b1;
    if (inject) begin
      start = 1'b1;
      pbSel = 2'd2;
    end
    guard = 0;
    while (!sRdy && guard < 50) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    if (guard >= 50) timeoutFail("byte handshake");
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one PB: start, byte stream (optional stall before byte stallAt,
  // optional start pulse with byte injectAt, optional surplus byte), then
  // waits for completion and for busy to drop.
  task automatic applyStimulus(input logic [1:0] sel, input int off, input int mode,
                               input int stallAt, input bit extraByte, input int injectAt);
    int nBytes, guard;
    nBytes = (sel == 2'd0) ? 16 : (sel == 2'd1) ? 136 : 520;
    startPb(sel, off);
    for (int i = 0; i < nBytes; i++) begin
      if (i == stallAt) begin
        sVld = 1'b0;
        guard = 0;
        while (!sRdy && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 50) timeoutFail("stall alignment");
        repeat (10) @(negedge clk);
      end
      sendByte(byteOf(mode, i), i == injectAt);
    end
    if (extraByte) begin
      sData = 8'hA5;
      sVld = 1'b1;
    end else begin
      sVld = 1'b0;
    end
    guard = 0;
    while (!done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) timeoutFail("done wait");
    repeat (2) @(negedge clk);
    sVld = 1'b0;
  endtask

  initial begin
    int guard;
    // Reset state
    #12;
    checkOutput("reset outputs", {sRdy, wen, dinVld, busy, done, err, wdata, waddr, pbOffset}, 64'd0);
    @(negedge clk);
    #2 nRst = 1'b1;

    // PB16, 0xE4 bytes, source always valid
    applyStimulus(2'd0, 0, 0, -1, 1'b0, -1);
    checkOutput("pb16 first wen", 64'(firstWr), 64'd2);
    checkOutput("pb16 last wen", 64'(lastWr), 64'd65);
    checkOutput("pb16 writes", 64'(wrCount), 64'd64);
    checkOutput("pb16 first din_vld", 64'(firstRd), 64'd66);
    checkOutput("pb16 last din_vld", 64'(lastRd), 64'd129);
    checkOutput("pb16 done cycle", 64'(doneRel), 64'd130);
    checkOutput("pb16 busy fall", 64'(busyFall), 64'd131);
    checkOutput("pb16 wdata pattern errors", 64'(e4Bad), 64'd0);
    checkOutput("pb16 offset errors", 64'(offBad), 64'd0);

    // Reserved PB size
    @(negedge clk);
    start = 1'b1;
    pbSel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("err pulse", 64'(err), 64'd1);
    checkOutput("busy after reserved sel", 64'(busy), 64'd0);
    checkOutput("s_rdy after reserved sel", 64'(sRdy), 64'd0);
    @(negedge clk);
    checkOutput("err one cycle", 64'(err), 64'd0);
    checkOutput("busy stays low", 64'(busy), 64'd0);

    // PB136 full rate
    applyStimulus(2'd1, 64, 1, -1, 1'b0, -1);
    checkOutput("pb136 writes", 64'(wrCount), 64'd544);
    checkOutput("pb136 reads", 64'(rdCount), 64'd544);
    checkOutput("pb136 first din_vld", 64'(firstRd), 64'd546);
    checkOutput("pb136 done cycle", 64'(doneRel), 64'd1090);
    checkOutput("pb136 busy fall", 64'(busyFall), 64'd1091);
    checkOutput("pb136 offset errors", 64'(offBad), 64'd0);

    // PB520 with a 10-cycle source stall where byte 6 is due
    applyStimulus(2'd2, 608, 1, 6, 1'b0, -1);
    checkOutput("pb520 writes", 64'(wrCount), 64'd2080);
    checkOutput("pb520 reads", 64'(rdCount), 64'd2080);
    checkOutput("pb520 gap length", 64'(gapCount), 64'd10);
    checkOutput("pb520 gap waddr", 64'(gapFirstAddr), 64'd24);
    checkOutput("pb520 gap waddr moves", 64'(gapAddrChanges), 64'd0);
    checkOutput("pb520 done cycle", 64'(doneRel), 64'd4172);
    checkOutput("pb520 offset errors", 64'(offBad), 64'd0);

    // PB16 with a surplus 17th byte and a start pulse while busy
    applyStimulus(2'd0, 0, 1, -1, 1'b1, 3);
    checkOutput("surplus handshakes", 64'(hsCount), 64'd16);
    checkOutput("busy start ignored done", 64'(doneRel), 64'd130);
    checkOutput("busy start offset errors", 64'(offBad), 64'd0);

    // Reset in the middle of a PB136 write phase, then a fresh PB16
    startPb(2'd1, 64);
    for (int i = 0; i < 26; i++) sendByte(byteOf(1, i), 1'b0);
    sVld = 1'b0;
    guard = 0;
    while (wrCount < 100 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 200) timeoutFail("100 writes wait");
    #2 nRst = 1'b0;
    #1;
    checkOutput("async reset outputs", {sRdy, wen, dinVld, busy, done, err, wdata, waddr, pbOffset}, 64'd0);
    repeat (2) @(negedge clk);
    #2 nRst = 1'b1;
    applyStimulus(2'd0, 0, 0, -1, 1'b0, -1);
    checkOutput("post-reset first waddr", 64'(firstWrAddr), 64'd0);
    checkOutput("post-reset first wen", 64'(firstWr), 64'd2);
    checkOutput("post-reset done cycle", 64'(doneRel), 64'd130);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hpgp_itl_wr_ctrl.md
# hpgp_itl_wr_ctrl

Write/read sequencer feeding the HPGP turbo interleaver dual-port RAM. It accepts a PB payload as a byte stream, splits each byte into 2-bit pairs, and writes them to RAM addresses 0..N-1. It then replays addresses 0..N-1 with writes disabled so the RAM emits natural-order and interleaved-order pairs to the constituent encoders. It supplies the RAM's `wdata`, `waddr`, `wen`, `pb_offset` and `din_vld` inputs.

## Interface
- `D_WIDTH`, 2, RAM data width (pair width); fixed at 2.
- `A_WIDTH`, 12, RAM/ROM address width.
- `clk`  in  1  single clock for all logic.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a PB; sampled only in IDLE.
- `pb_sel`  in  2  PB size, sampled with `start`: 0=PB16 (N=64 pairs, offset 0), 1=PB136 (N=544, offset 64), 2=PB520 (N=2080, offset 608), 3=reserved.
- `s_data`  in  8  payload byte.
- `s_vld`  in  1  `s_data` valid.
- `s_rdy`  out  1  byte accepted when `s_vld && s_rdy`.
- `wdata`  out  D_WIDTH  pair to RAM.
- `waddr`  out  A_WIDTH  RAM write/read address, 0..N-1.
- `pb_offset`  out  A_WIDTH  ROM table offset for the selected PB size.
- `wen`  out  1  RAM write enable.
- `din_vld`  out  1  read-sweep valid to RAM (RAM `dout_vld` follows 2 cycles later).
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse at PB completion.
- `err`  out  1  one-cycle pulse on `start` with `pb_sel`=3.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On `start` with a valid `pb_sel`, latch N (`nbytes` = N/4) and `pb_offset`, then go to WRITE.
  - On `start` with `pb_sel`=3, pulse `err` next cycle and stay in IDLE.
- WRITE:
  - Holds a one-byte buffer (`buf_full`) and a 2-bit pair index `k`.
  - `s_rdy` = (`!buf_full` || `k`==3) && bytes_accepted < `nbytes`. This gives 1 byte per 4 cycles with no bubbles.
  - While `buf_full`, every cycle: `wen`=1, `wdata`=byte[2k+1:2k] (LSB pair first), `waddr`=write count, `k`++.
  - At `k`==3, the buffer empties unless it is reloaded in the same cycle.
  - When the write at `waddr`=N-1 has been issued, go to READ.
  - Source stalls (`s_vld`=0) insert cycles with `wen`=0. `waddr` holds its value and does not advance.
- READ:
  - `wen`=0, `din_vld`=1, `waddr` = 0,1,…,N-1 on consecutive cycles, with no stalls.
  - After N-1, go to DONE.
- DONE:
  - `done`=1 for one cycle, then IDLE.
- `pb_offset` is held constant from WRITE entry until return to IDLE. It is 0 in IDLE.
- `start` outside IDLE is ignored.
- Bytes offered beyond `nbytes` are not accepted (`s_rdy`=0).
- All counters are unsigned, A_WIDTH bits. They never wrap, because N ≤ 2080 < 2^A_WIDTH.

## Timing
- All outputs are registered except `s_rdy`, which is combinational from state/buffer/count.
- Reset values: state=IDLE; `s_rdy`, `wdata`, `waddr`, `pb_offset`, `wen`, `din_vld`, `busy`, `done`, `err` = 0.
- Cycle T: `start` sampled. T+1: state WRITE, `busy`=1, `s_rdy`=1. The first byte accepted at T+1 gives `wen`=1 at T+2.
- Unstalled source: writes occupy T+2..T+N+1; READ occupies T+N+2..T+2N+1; `done` at T+2N+2; `busy`=0 from T+2N+3.
- A write and a byte acceptance in the same cycle (`k`==3) are legal and required for full rate.
- Last-write to first-read spacing is exactly one cycle. RAM writes land before the RAM's registered read path samples them.
- `n_rst` low at any point:
  - All state and outputs return to reset values asynchronously.
  - The partial byte and counters are discarded.
  - RAM contents are not cleared.
  - The next PB requires a new `start`.

## Test plan
- Reset mid-WRITE of PB136 (after 100 writes) -> all outputs 0 immediately. A fresh PB16 `start` then completes normally with `waddr` restarting at 0.
- PB16, `start` at cycle 0, bytes 0xE4 ×16 with `s_vld` held high:
  - `wen` cycles 2..65 with `waddr` 0..63 and `wdata` repeating 0,1,2,3.
  - `din_vld` cycles 66..129 with `waddr` 0..63 and `wen`=0.
  - `done` at 130; `pb_offset`=0 throughout.
- PB136, `pb_offset`=64 from cycle 1 to `done`:
  - 136 bytes produce 544 writes, then 544 reads.
  - `done` at cycle 1090; `busy` falls at 1091.
- PB520 with `s_vld` deasserted for 10 cycles after byte 5:
  - `wen` gap of exactly 10 cycles, `waddr` held at 24 during the gap.
  - Total writes = 2080; `pb_offset`=608; `done` at 4172.
- `pb_sel`=3 with `start` -> `err` pulse next cycle, `busy` stays 0, `s_rdy` stays 0. `start` pulses during `busy` are ignored: no restart, offset unchanged.
- Source offers 17 bytes for PB16 -> only 16 accepted. `s_rdy`=0 after the 16th byte; the 17th byte remains pending unconsumed.
